addx_result_buffer: RTL and testbench
=====================================

// Module: addx_result_buffer
// PURPOSE
//  Downstream stage of the ADDX saturating-add accelerator. It captures each ADDX result
//  together with its transaction ID and saturation flag, and queues them in an in-order FIFO.
//  It presents them to the writeback port with a valid/ready handshake, decoupling
//  accelerator issue from writeback arbitration.
//  It also keeps a retired-saturation event counter for performance monitoring.
// PARAMETERS
//  XLEN           64  datapath width of the result (32 or 64)
//  TRANS_ID_BITS  3   width of the scoreboard transaction ID
//  DEPTH          4   FIFO entries; power of two, >= 2
// PORTS
//  clk_i            in   1                  single clock; all logic on its rising edge
//  rst_i            in   1                  synchronous active-high reset
//  flush_i          in   1                  pipeline flush; discards all queued entries
//  addx_valid_i     in   1                  accelerator result valid
//  addx_ready_o     out  1                  buffer can accept a result this cycle
//  addx_result_i    in   XLEN               saturated ADDX result
//  addx_trans_id_i  in   TRANS_ID_BITS      transaction ID of the result
//  addx_sat_i       in   1                  1 = result was clamped (signed overflow)
//  wb_valid_o       out  1                  head entry valid toward writeback
//  wb_ready_i       in   1                  writeback accepts the head entry
//  wb_result_o      out  XLEN               head entry result
//  wb_trans_id_o    out  TRANS_ID_BITS      head entry transaction ID
//  wb_sat_o         out  1                  head entry saturation flag
//  count_o          out  $clog2(DEPTH)+1    number of occupied entries
//  sat_events_o     out  32                 retired saturated results, sticky at max
// BEHAVIOUR
//  - Reset (rst_i=1 at a clock edge): pointers=0, count_o=0, sat_events_o=0,
//    wb_valid_o=0, addx_ready_o=1 from the next cycle. Reset overrides flush, push and pop
//    in the same cycle. Reset during back-to-back traffic drops everything.
//  - Push: addx_valid_i && addx_ready_o. Write {result, trans_id, sat} at wr_ptr;
//    wr_ptr advances modulo DEPTH.
//  - addx_ready_o = (count_o != DEPTH). It is purely registered-state derived, with no
//    combinational path from wb_ready_i.
//  - Pop: wb_valid_o && wb_ready_i. rd_ptr advances modulo DEPTH.
//  - wb_valid_o = (count_o != 0). wb_* data come from the storage at rd_ptr. They are
//    driven to 0 when the buffer is empty.
//  - Latency: a result pushed into an empty buffer appears on wb_* in the next cycle (1 cycle).
//    There is no bypass.
//  - Ordering: strict FIFO. Results leave in push order regardless of trans_id.
//  - Simultaneous push and pop, not full: count_o is unchanged and both pointers advance.
//  - Full: addx_ready_o=0. A push attempt is ignored, and the upstream must hold its data.
//    A pop in the same cycle does not enable a push that cycle. addx_ready_o rises the
//    following cycle.
//  - Empty: a pop is impossible because wb_valid_o=0. wb_ready_i is ignored.
//  - Held data: while wb_valid_o=1 and wb_ready_i=0, the wb_* outputs stay stable.
//  - Flush (flush_i=1, rst_i=0): pointers and count go to 0 at the edge. A push and a pop
//    in the flush cycle are discarded. A pop in the flush cycle does not count toward
//    sat_events_o. sat_events_o is NOT cleared by flush.
//  - sat_events_o: +1 on every pop with wb_sat_o=1, excluding flush cycles. It saturates
//    at 32'hFFFF_FFFF and never wraps.
//  - The pointer wrap uses $clog2(DEPTH)-bit pointers plus the separate count register.
//    count_o is always <= DEPTH.
// TESTING
//  1 Reset, then push {res=64'h7FFF_FFFF_FFFF_FFFF, id=3, sat=1} with wb_ready_i=0
//    -> next cycle wb_valid_o=1, wb_trans_id_o=3, wb_sat_o=1, count_o=1.
//    Then assert wb_ready_i -> count_o=0 and sat_events_o=1.
//  2 Push ids 0,1,2,3 with wb_ready_i=0 -> count_o=4, addx_ready_o=0.
//    A 5th push (id=4) is ignored. Drain -> the ids emerge in order 0,1,2,3.
//  3 Stream 12 pushes (ids 0..7 repeating) with wb_ready_i=1 every cycle -> the same ids
//    pop in order, count_o stays <=1, and the pointers wrap without loss.
//  4 With 3 entries queued, assert flush_i together with a push and a pop
//    -> next cycle count_o=0, wb_valid_o=0, and sat_events_o is unchanged.
//  5 Preload sat_events_o to 32'hFFFF_FFFE via a force, then pop 2 entries with sat=1
//    -> the counter reads 32'hFFFF_FFFF and stays there.
//  6 Full buffer with push and pop in the same cycle -> count_o=3, the push is dropped,
//    and addx_ready_o=1 the next cycle. Assert rst_i mid-stream -> all outputs read their
//    reset values the next cycle.

Source files
------------

// File: rtl/addx_result_buffer.sv
// -----------------------------------------------------------------------------
// addx_result_buffer
//
// Result FIFO behind the ADDX saturating-add accelerator. Each accepted result is
// stored with its transaction ID and its saturation flag. Entries are then offered
// to writeback in the order they were pushed, using a valid/ready handshake.
// The block also counts how many saturated results have retired.
//
// Ports
//   clk_i            rising-edge clock
//   rst_i            synchronous active-high reset
//   flush_i          drops every queued entry; sat_events_o is kept
//   addx_valid_i     accelerator result valid
//   addx_ready_o     buffer has a free entry (depends on registered state only)
//   addx_result_i    XLEN-bit saturated result
//   addx_trans_id_i  transaction ID of the result
//   addx_sat_i       result was clamped
//   wb_valid_o       head entry valid toward writeback
//   wb_ready_i       writeback takes the head entry
//   wb_result_o      head entry result (0 when empty)
//   wb_trans_id_o    head entry transaction ID (0 when empty)
//   wb_sat_o         head entry saturation flag (0 when empty)
//   count_o          number of occupied entries
//   sat_events_o     retired saturated results; holds at all-ones, never wraps
// -----------------------------------------------------------------------------
module addx_result_buffer #(
  parameter int XLEN          = 64,
  parameter int TRANS_ID_BITS = 3,
  parameter int DEPTH         = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       addx_valid_i,
  output logic                       addx_ready_o,
  input  logic [XLEN-1:0]            addx_result_i,
  input  logic [TRANS_ID_BITS-1:0]   addx_trans_id_i,
  input  logic                       addx_sat_i,
  output logic                       wb_valid_o,
  input  logic                       wb_ready_i,
  output logic [XLEN-1:0]            wb_result_o,
  output logic [TRANS_ID_BITS-1:0]   wb_trans_id_o,
  output logic                       wb_sat_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [31:0]                sat_events_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [31:0]      SAT_MAX = 32'hFFFF_FFFF;

  // Storage
  logic [XLEN-1:0]          mem_result_r [DEPTH];
  logic [TRANS_ID_BITS-1:0] mem_id_r     [DEPTH];
  logic                     mem_sat_r    [DEPTH];

  // Control state
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [31:0]      sat_events_r;
  // ready_r and valid_r always mirror (count_r != DEPTH) and (count_r != 0).
  // They are kept as flops so the handshake outputs come straight from registers.
  logic             ready_r;
  logic             valid_r;

  logic             push_s;
  logic             pop_s;
  logic [CNT_W-1:0] count_next_s;
  logic             sat_inc_s;
  logic [31:0]      sat_next_s;

  // Handshake qualification, next occupancy and next saturation-counter value
  always_comb begin
    push_s       = addx_valid_i & ready_r;
    pop_s        = valid_r & wb_ready_i;
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
    // A pop that coincides with a flush is discarded, so it is not counted.
    sat_inc_s  = pop_s & mem_sat_r[rd_ptr_r] & ~flush_i;
    sat_next_s = sat_events_r;
    if (sat_inc_s && (sat_events_r != SAT_MAX)) begin
      sat_next_s = sat_events_r + 32'd1;
    end else begin
      sat_next_s = sat_events_r;
    end
  end

  // Pointers, occupancy, handshake flags and the saturation counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      count_r      <= {CNT_W{1'b0}};
      sat_events_r <= 32'd0;
      ready_r      <= 1'b1;
      valid_r      <= 1'b0;
    end else if (flush_i) begin
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      count_r      <= {CNT_W{1'b0}};
      sat_events_r <= sat_next_s;
      ready_r      <= 1'b1;
      valid_r      <= 1'b0;
    end else begin
      // Because DEPTH is a power of two, natural pointer overflow gives the modulo wrap.
      wr_ptr_r     <= push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
      rd_ptr_r     <= pop_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
      count_r      <= count_next_s;
      sat_events_r <= sat_next_s;
      ready_r      <= (count_next_s != DEPTH_C);
      valid_r      <= (count_next_s != {CNT_W{1'b0}});
    end
  end

  // Entry storage write; the storage is a plain RAM and needs no reset
  always_ff @(posedge clk_i) begin
    if (push_s && !flush_i && !rst_i) begin
      mem_result_r[wr_ptr_r] <= addx_result_i;
      mem_id_r[wr_ptr_r]     <= addx_trans_id_i;
      mem_sat_r[wr_ptr_r]    <= addx_sat_i;
    end
  end

  // Head entry is read from registered storage. It is forced to zero while the buffer is empty.
  assign wb_result_o   = valid_r ? mem_result_r[rd_ptr_r] : {XLEN{1'b0}};
  assign wb_trans_id_o = valid_r ? mem_id_r[rd_ptr_r]     : {TRANS_ID_BITS{1'b0}};
  assign wb_sat_o      = valid_r ? mem_sat_r[rd_ptr_r]    : 1'b0;
  assign wb_valid_o    = valid_r;
  assign addx_ready_o  = ready_r;
  assign count_o       = count_r;
  assign sat_events_o  = sat_events_r;

endmodule

// File: tb/tb_addx_result_buffer.sv
// Bench for addx_result_buffer. The reference model is a queue of entries plus a
// saturating counter. It is updated once per clock from the documented rules.
module tb_addx_result_buffer;

  localparam int XLEN  = 64;
  localparam int IDW   = 3;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             flush_i = 1'b0;
  logic             addx_valid_i = 1'b0;
  logic             addx_ready_o;
  logic [XLEN-1:0]  addx_result_i = '0;
  logic [IDW-1:0]   addx_trans_id_i = '0;
  logic             addx_sat_i = 1'b0;
  logic             wb_valid_o;
  logic             wb_ready_i = 1'b0;
  logic [XLEN-1:0]  wb_result_o;
  logic [IDW-1:0]   wb_trans_id_o;
  logic             wb_sat_o;
  logic [$clog2(DEPTH):0] count_o;
  logic [31:0]      sat_events_o;

  addx_result_buffer #(.XLEN(XLEN), .TRANS_ID_BITS(IDW), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .addx_valid_i(addx_valid_i), .addx_ready_o(addx_ready_o),
    .addx_result_i(addx_result_i), .addx_trans_id_i(addx_trans_id_i),
    .addx_sat_i(addx_sat_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_result_o(wb_result_o), .wb_trans_id_o(wb_trans_id_o), .wb_sat_o(wb_sat_o),
    .count_o(count_o), .sat_events_o(sat_events_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] result;
    logic [IDW-1:0]  id;
    logic            sat;
  } entry_t;

  entry_t      mq[$];
  longint      m_sat = 0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    entry_t h;
    bit     ne;
    ne = (mq.size() != 0);
    if (ne) h = mq[0];
    else begin h.result = '0; h.id = '0; h.sat = 1'b0; end
    chk({tag, ".count"}, 64'(count_o), 64'(mq.size()));
    chk({tag, ".ready"}, 64'(addx_ready_o), 64'(mq.size() != DEPTH));
    chk({tag, ".valid"}, 64'(wb_valid_o), 64'(ne));
    chk({tag, ".result"}, wb_result_o, h.result);
    chk({tag, ".id"}, 64'(wb_trans_id_o), 64'(h.id));
    chk({tag, ".sat"}, 64'(wb_sat_o), 64'(h.sat));
    chk({tag, ".sat_events"}, 64'(sat_events_o), 64'(m_sat));
  endtask

  // One clock: decide model push/pop from pre-edge state, advance, then compare.
  task automatic cycle(input string tag);
    bit     do_push, do_pop;
    entry_t e;
    do_push = addx_valid_i && (mq.size() < DEPTH);
    do_pop  = wb_ready_i && (mq.size() != 0);
    e.result = addx_result_i; e.id = addx_trans_id_i; e.sat = addx_sat_i;
    @(posedge clk);
    if (rst_i) begin
      mq.delete();
      m_sat = 0;
    end else if (flush_i) begin
      mq.delete();
    end else begin
      if (do_pop) begin
        if (mq[0].sat && m_sat < 64'hFFFF_FFFF) m_sat++;
        void'(mq.pop_front());
      end
      if (do_push) mq.push_back(e);
    end
    #1;
    check_all(tag);
  endtask

  task automatic set_push(input bit v, input logic [IDW-1:0] id, input bit sat);
    addx_valid_i    = v;
    addx_trans_id_i = id;
    addx_sat_i      = sat;
    addx_result_i   = {$urandom, $urandom};
  endtask

  initial begin
    // Reset
    rst_i = 1'b1;
    cycle("reset0");
    cycle("reset1");
    rst_i = 1'b0;

    // 1: single saturated result, held then popped
    addx_valid_i = 1'b1; addx_result_i = 64'h7FFF_FFFF_FFFF_FFFF;
    addx_trans_id_i = 3'd3; addx_sat_i = 1'b1; wb_ready_i = 1'b0;
    cycle("t1_push");
    chk("t1_id3", 64'(wb_trans_id_o), 64'd3);
    addx_valid_i = 1'b0;
    cycle("t1_hold");
    wb_ready_i = 1'b1;
    cycle("t1_pop");
    chk("t1_sat_events", 64'(sat_events_o), 64'd1);
    wb_ready_i = 1'b0;

    // 2: fill, overfill attempt, drain in order
    for (int i = 0; i < 4; i++) begin
      set_push(1'b1, IDW'(i), i[0]);
      cycle("t2_fill");
    end
    chk("t2_full_ready", 64'(addx_ready_o), 64'd0);
    set_push(1'b1, 3'd4, 1'b0);
    cycle("t2_overfill");
    addx_valid_i = 1'b0; wb_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_order", 64'(wb_trans_id_o), 64'(i));
      cycle("t2_drain");
    end
    wb_ready_i = 1'b0;

    // 3: streaming with wrap
    wb_ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      set_push(1'b1, IDW'(i % 8), 1'($urandom_range(0, 1)));
      cycle("t3_stream");
      chk("t3_count_le1", 64'(count_o <= 1), 64'd1);
    end
    addx_valid_i = 1'b0;
    cycle("t3_tail");
    wb_ready_i = 1'b0;

    // 4: flush with push and pop in the same cycle
    for (int i = 0; i < 3; i++) begin
      set_push(1'b1, IDW'(i + 5), 1'b1);
      cycle("t4_fill");
    end
    flush_i = 1'b1; wb_ready_i = 1'b1; set_push(1'b1, 3'd1, 1'b1);
    cycle("t4_flush");
    flush_i = 1'b0; addx_valid_i = 1'b0; wb_ready_i = 1'b0;
    cycle("t4_after");

    // 5: saturation of the event counter
    for (int i = 0; i < 2; i++) begin
      set_push(1'b1, IDW'(i), 1'b1);
      cycle("t5_fill");
    end
    addx_valid_i = 1'b0;
    force dut.sat_events_r = 32'hFFFF_FFFE;
    m_sat = 64'hFFFF_FFFE;
    cycle("t5_force");
    release dut.sat_events_r;
    wb_ready_i = 1'b1;
    cycle("t5_pop1");
    cycle("t5_pop2");
    chk("t5_max", 64'(sat_events_o), 64'hFFFF_FFFF);
    cycle("t5_stay");
    wb_ready_i = 1'b0;

    // 6: full with simultaneous push and pop, then reset mid-stream
    for (int i = 0; i < 4; i++) begin
      set_push(1'b1, IDW'(i), 1'b0);
      cycle("t6_fill");
    end
    set_push(1'b1, 3'd7, 1'b1); wb_ready_i = 1'b1;
    cycle("t6_full_pushpop");
    chk("t6_count3", 64'(count_o), 64'd3);
    chk("t6_ready", 64'(addx_ready_o), 64'd1);
    for (int i = 0; i < 3; i++) begin
      set_push(1'b1, IDW'(i), 1'b1);
      cycle("t6_stream");
    end
    rst_i = 1'b1;
    cycle("t6_reset");
    chk("t6_rst_count", 64'(count_o), 64'd0);
    chk("t6_rst_valid", 64'(wb_valid_o), 64'd0);
    rst_i = 1'b0; addx_valid_i = 1'b0; wb_ready_i = 1'b0;
    cycle("t6_idle");

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      set_push(1'($urandom_range(0, 3) != 0), IDW'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)));
      wb_ready_i = ($urandom_range(0, 2) != 0);
      flush_i    = ($urandom_range(0, 39) == 0);
      rst_i      = ($urandom_range(0, 149) == 0);
      cycle("rand");
    end
    rst_i = 1'b0; flush_i = 1'b0; addx_valid_i = 1'b0; wb_ready_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
